nano_mem_responder: RTL and testbench
=====================================

# nano_mem_responder

Synthesizable memory responder for the NanoCPU bus (address/dataR/dataW/ce/we). It owns the 256 × 16-bit program/data store, clears it after reset and accepts a program image over a valid/ready load port while holding the CPU in reset. It then services CPU reads and writes, with one memory-mapped output register. It replaces the behavioural memory array used around the CPU in simulation.

## Interface

Parameters:
- ADDR_W, default 8: CPU address width (256 words).
- DATA_W, default 16: word width.
- IO_ADDR, default 8'hFF: address decoded to the output register instead of RAM.

Ports:
- ck in 1: the single clock; all state updates on its rising edge.
- rst in 1: reset, asynchronous and active-high.
- address in ADDR_W: CPU word address.
- dataW in DATA_W: CPU write data.
- ce in 1: CPU access enable.
- we in 1: CPU write enable; qualified by ce.
- dataR out DATA_W: read data, combinational from address.
- load_valid in 1: loader beat valid.
- load_ready out 1: responder accepts a beat.
- load_addr in ADDR_W: loader word address.
- load_data in DATA_W: loader word.
- load_last in 1: final beat of the image.
- cpu_rst out 1: reset to NanoCPU; high until the image is loaded.
- io_out out DATA_W: output register.
- io_strobe out 1: one-cycle pulse on each io_out write.
- rd_count out 16: CPU read counter (see Configuration).
- wr_count out 16: CPU write counter (see Configuration).

## Operation

- FSM states: CLEAR, LOAD, RUN.
- Reset:
  - Enters CLEAR with the clear index at 0.
  - Outputs: cpu_rst=1, load_ready=0, io_out=0, io_strobe=0, dataR=0, rd_count=0, wr_count=0.
- CLEAR:
  - Writes 0 to mem[index], one word per cycle.
  - Index 0..255, 256 cycles total.
  - After writing index 255, goes to LOAD. The index is 8 bits and wraps to 0, unused afterwards.
- LOAD:
  - load_ready=1.
  - On load_valid && load_ready: mem[load_addr] <= load_data.
  - A load_addr equal to IO_ADDR writes RAM, not io_out.
  - Beat with load_last=1: word is written, then the FSM goes to RUN.
  - Repeated addresses: last write wins.
- RUN:
  - load_ready=0; load port ignored.
  - Read path: dataR = mem[address] for any address except IO_ADDR, which returns io_out. Driven regardless of ce.
  - Write, ce && we && address != IO_ADDR: mem[address] <= dataW.
  - Write, ce && we && address == IO_ADDR: io_out <= dataW and io_strobe=1 for the next cycle; RAM untouched.
  - RUN is left only via rst.
- dataR is 0 in CLEAR and LOAD.
- Write/read on the same cycle and address: dataR shows the old value until the following cycle.
- Reset mid-operation (any state, including mid-LOAD): everything returns to the reset values and CLEAR restarts, so partially loaded words are erased.

## Timing

- cpu_rst is registered.
  - It falls on the first edge after the FSM enters RUN, i.e. 2 edges after the load_last beat is accepted.
  - It rises asynchronously with rst.
- Reset release to load_ready=1: 256 rising edges.
- Read latency: 0 cycles (combinational). Write latency: visible 1 cycle later.
- io_strobe: exactly 1 cycle per accepted IO write. Back-to-back IO writes hold it high on consecutive cycles.
- Counters update 1 cycle after the counted access.

## Configuration

- NANO_MEM_STATS_EN defined:
  - In RUN, rd_count increments on ce && !we; wr_count increments on ce && we, including IO writes.
  - Both counters saturate at 16'hFFFF and clear only on rst.
- NANO_MEM_STATS_EN undefined: counter logic is not built; rd_count and wr_count are tied to 0.

## Structure

- Package nano_mem_pkg: state enum (CLEAR, LOAD, RUN), ADDR_W, DATA_W, IO_ADDR default, memory word typedef.
- Sub-module nano_sat_counter: 16-bit saturating counter with async active-high reset and increment enable. Instantiated twice under NANO_MEM_STATS_EN.

## Test plan

1. Reset, then release with the loader idle:
   - cpu_rst=1, load_ready=0 and dataR=0 for 256 cycles.
   - load_ready=1 on cycle 257.
2. Load beats {0:16'h4000, 1:16'h4111, 2:16'h0093 with load_last}:
   - cpu_rst falls 2 edges after the last beat.
   - address=1 gives dataR=16'h4111; address=3 gives 16'h0000 (cleared).
3. In RUN, ce=we=1, address=10, dataW=16'h002D:
   - dataR=16'h0000 in the same cycle, 16'h002D on the next.
4. In RUN, write 16'h00AB to address 8'hFF:
   - io_out=16'h00AB with io_strobe high for exactly one cycle.
   - Reading 8'hFF returns 16'h00AB.
5. Assert rst after two LOAD beats (addresses 0 and 1), then release and rerun CLEAR:
   - The loader stays idle (load_valid=0) until load_ready returns.
   - After CLEAR, addresses 0 and 1 read 0; cpu_rst stays high throughout.
6. With NANO_MEM_STATS_EN:
   - 5 reads and 3 writes in RUN give rd_count=5 and wr_count=3.
   - rd_count preset near 16'hFFFF (forced in the bench) holds at 16'hFFFF after further reads.
   - Without the macro, both counters read 0.

Source files
------------

// File: rtl/nano_mem_pkg.sv
// rtl/nano_mem_pkg.sv - shared types and defaults for nano_mem_responder
package nano_mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam logic [7:0] IO_ADDR = 8'hFF;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_e;

   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/nano_sat_counter.sv
// rtl/nano_sat_counter.sv - 16-bit saturating event counter
module nano_sat_counter (
   input  logic        ck,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         count_q <= 16'h0000;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'h0001;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/nano_mem_responder.sv
// rtl/nano_mem_responder.sv - NanoCPU memory responder: clear, image load, run
// Optional access counters are built when NANO_MEM_STATS_EN is defined.
module nano_mem_responder #(
   parameter int ADDR_W = nano_mem_pkg::ADDR_W,
   parameter int DATA_W = nano_mem_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(nano_mem_pkg::IO_ADDR)
) (
   input  logic              ck,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataW,
   input  logic              ce,
   input  logic              we,
   output logic [DATA_W-1:0] dataR,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              cpu_rst,
   output logic [DATA_W-1:0] io_out,
   output logic              io_strobe,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   import nano_mem_pkg::*;

   localparam int DEPTH = 2 ** ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              io_wr;
   logic              run;

   assign run = (state_q == RUN);

   // Single RAM write port shared by the clear sweep, the loader and the CPU.
   always_comb begin
      state_d    = state_q;
      mem_we     = 1'b0;
      mem_waddr  = clr_idx_q;
      mem_wdata  = '0;
      load_ready = 1'b0;
      io_wr      = 1'b0;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            if (clr_idx_q == '1) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               mem_we    = 1'b1;
               mem_waddr = load_addr;
               mem_wdata = load_data;
               if (load_last) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (ce && we) begin
               if (address == IO_ADDR) begin
                  io_wr = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = address;
                  mem_wdata = dataW;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         cpu_rst   <= 1'b1;
         io_out    <= '0;
         io_strobe <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
         end
         cpu_rst   <= !run;
         io_strobe <= io_wr;
         if (io_wr) begin
            io_out <= dataW;
         end
      end
   end

   // RAM has no reset; the CLEAR sweep after every reset provides the zeroing.
   always_ff @(posedge ck) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      dataR = '0;
      if (run) begin
         dataR = (address == IO_ADDR) ? io_out : mem[address];
      end
   end

`ifdef NANO_MEM_STATS_EN
   nano_sat_counter u_rd_count (
      .ck    (ck),
      .rst   (rst),
      .inc   (run && ce && !we),
      .count (rd_count)
   );

   nano_sat_counter u_wr_count (
      .ck    (ck),
      .rst   (rst),
      .inc   (run && ce && we),
      .count (wr_count)
   );
`else
   assign rd_count = 16'h0000;
   assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_nano_mem_responder.sv
// tb/tb_nano_mem_responder.sv - scoreboard bench for nano_mem_responder
module tb_nano_mem_responder;

   logic        ck = 1'b0;
   logic        rst;
   logic [7:0]  address;
   logic [15:0] dataW;
   logic        ce;
   logic        we;
   logic [15:0] dataR;
   logic        load_valid;
   logic        load_ready;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic        load_last;
   logic        cpu_rst;
   logic [15:0] io_out;
   logic        io_strobe;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

`ifdef NANO_MEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   nano_mem_responder u_dut (
      .ck         (ck),
      .rst        (rst),
      .address    (address),
      .dataW      (dataW),
      .ce         (ce),
      .we         (we),
      .dataR      (dataR),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_last  (load_last),
      .cpu_rst    (cpu_rst),
      .io_out     (io_out),
      .io_strobe  (io_strobe),
      .rd_count   (rd_count),
      .wr_count   (wr_count)
   );

   always #5 ck = ~ck;

   typedef enum {S_DATAR, S_LOAD_READY, S_CPU_RST, S_IO_OUT, S_IO_STROBE, S_RD, S_WR} sel_e;
   typedef struct {
      sel_e        sel;
      logic [15:0] val;
      string       name;
   } chk_t;

   chk_t        exp_q[$];
   logic [15:0] io_q[$];
   int          passed = 0;
   int          total  = 0;
   int          exp_rd = 0;
   int          exp_wr = 0;

   function automatic logic [15:0] sample(sel_e s);
      case (s)
         S_DATAR:      return dataR;
         S_LOAD_READY: return {15'h0, load_ready};
         S_CPU_RST:    return {15'h0, cpu_rst};
         S_IO_OUT:     return io_out;
         S_IO_STROBE:  return {15'h0, io_strobe};
         S_RD:         return rd_count;
         default:      return wr_count;
      endcase
   endfunction

   function automatic logic [15:0] stat(int n);
      return STATS ? 16'(n) : 16'h0000;
   endfunction

   // Monitor: drains expectations and every io_strobe beat on the falling edge.
   always @(negedge ck) begin
      chk_t        c;
      logic [15:0] act;
      logic [15:0] ev;
      while (exp_q.size() > 0) begin
         c   = exp_q.pop_front();
         act = sample(c.sel);
         total++;
         if (act === c.val) passed++;
         else $display("FAIL %s: got %h expected %h", c.name, act, c.val);
      end
      if (io_strobe === 1'b1) begin
         total++;
         if (io_q.size() == 0) begin
            $display("FAIL io_strobe_extra: got strobe with io_out=%h expected no strobe", io_out);
         end else begin
            ev = io_q.pop_front();
            if (io_out === ev) passed++;
            else $display("FAIL io_strobe_data: got %h expected %h", io_out, ev);
         end
      end
   end

   task automatic expect_sig(sel_e s, logic [15:0] v, string n);
      chk_t c;
      c.sel  = s;
      c.val  = v;
      c.name = n;
      exp_q.push_back(c);
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic wait_load_ready(string n, bit chk_rst);
      for (int i = 0; i < 300; i++) begin
         if (load_ready === 1'b1) return;
         if (chk_rst) expect_sig(S_CPU_RST, 16'h1, {n, "_cpu_rst"});
         tick();
      end
      total++;
      $display("FAIL %s: load_ready=%b after 300 cycles, expected 1", n, load_ready);
   endtask

   task automatic load_beat(logic [7:0] a, logic [15:0] d, logic l);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      load_last  = l;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic check_read(logic [7:0] a, logic [15:0] v, string n);
      address = a;
      expect_sig(S_DATAR, v, n);
      tick();
   endtask

   task automatic cpu_read(logic [7:0] a, logic [15:0] v);
      address = a;
      ce = 1'b1;
      we = 1'b0;
      expect_sig(S_DATAR, v, "cpu_read_data");
      tick();
      ce = 1'b0;
      exp_rd++;
   endtask

   task automatic cpu_write(logic [7:0] a, logic [15:0] d);
      address = a;
      dataW = d;
      ce = 1'b1;
      we = 1'b1;
      tick();
      ce = 1'b0;
      we = 1'b0;
      exp_wr++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      address = 8'h00; dataW = 16'h0; ce = 1'b0; we = 1'b0;
      load_valid = 1'b0; load_addr = 8'h00; load_data = 16'h0; load_last = 1'b0;
      #1 rst = 1'b1;
      tick();
      expect_sig(S_CPU_RST,    16'h1, "rst_cpu_rst");
      expect_sig(S_LOAD_READY, 16'h0, "rst_load_ready");
      expect_sig(S_DATAR,      16'h0, "rst_dataR");
      expect_sig(S_IO_OUT,     16'h0, "rst_io_out");
      expect_sig(S_IO_STROBE,  16'h0, "rst_io_strobe");
      expect_sig(S_RD,         16'h0, "rst_rd_count");
      expect_sig(S_WR,         16'h0, "rst_wr_count");
      tick();
      rst = 1'b0;

      // Clear sweep: 255 edges still busy, ready on the 256th.
      for (int i = 0; i < 255; i++) begin
         tick();
         expect_sig(S_LOAD_READY, 16'h0, "clear_load_ready");
         expect_sig(S_CPU_RST, 16'h1, "clear_cpu_rst");
         if (i % 64 == 0) begin
            address = 8'(i);
            expect_sig(S_DATAR, 16'h0, "clear_dataR");
         end
      end
      tick();
      expect_sig(S_LOAD_READY, 16'h1, "load_ready_at_256");

      load_beat(8'h00, 16'h4000, 1'b0);
      load_beat(8'h01, 16'h4111, 1'b0);
      load_beat(8'hFF, 16'h1234, 1'b0);
      load_beat(8'h05, 16'hAAAA, 1'b0);
      load_beat(8'h05, 16'h5555, 1'b0);
      load_beat(8'h02, 16'h0093, 1'b1);
      address = 8'h01;
      expect_sig(S_CPU_RST,    16'h1, "cpu_rst_edge1");
      expect_sig(S_LOAD_READY, 16'h0, "run_load_ready");
      expect_sig(S_DATAR,      16'h4111, "run_read_1_early");
      tick();
      expect_sig(S_CPU_RST, 16'h0, "cpu_rst_edge2");
      tick();
      check_read(8'h01, 16'h4111, "read_1");
      check_read(8'h00, 16'h4000, "read_0");
      check_read(8'h02, 16'h0093, "read_2");
      check_read(8'h03, 16'h0000, "read_3_cleared");
      check_read(8'h05, 16'h5555, "read_5_last_wins");
      check_read(8'hFF, 16'h0000, "read_ff_not_loaded");
      expect_sig(S_IO_OUT, 16'h0, "io_out_untouched_by_load");

      address = 8'd10; dataW = 16'h002D; ce = 1'b1; we = 1'b1;
      expect_sig(S_DATAR, 16'h0000, "write_same_cycle_old");
      tick();
      ce = 1'b0; we = 1'b0; exp_wr++;
      expect_sig(S_DATAR, 16'h002D, "write_next_cycle_new");
      tick();

      address = 8'hFF; dataW = 16'h00AB; ce = 1'b1; we = 1'b1;
      io_q.push_back(16'h00AB);
      tick();
      ce = 1'b0; we = 1'b0; exp_wr++;
      expect_sig(S_IO_OUT,    16'h00AB, "io_out_ab");
      expect_sig(S_DATAR,     16'h00AB, "read_ff_io");
      expect_sig(S_IO_STROBE, 16'h1, "io_strobe_high");
      tick();
      expect_sig(S_IO_STROBE, 16'h0, "io_strobe_one_cycle");
      dataW = 16'h0011; ce = 1'b1; we = 1'b1;
      io_q.push_back(16'h0011);
      tick();
      dataW = 16'h0022;
      io_q.push_back(16'h0022);
      tick();
      ce = 1'b0; we = 1'b0; exp_wr += 2;
      tick();
      expect_sig(S_IO_STROBE, 16'h0, "io_strobe_b2b_end");
      expect_sig(S_RD, stat(exp_rd), "rd_count_pre");
      expect_sig(S_WR, stat(exp_wr), "wr_count_pre");
      tick();

      // Reset from RUN, then again in the middle of a fresh load.
      rst = 1'b1;
      #1;
      expect_sig(S_CPU_RST, 16'h1, "rst_run_cpu_rst");
      expect_sig(S_IO_OUT,  16'h0, "rst_run_io_out");
      expect_sig(S_DATAR,   16'h0, "rst_run_dataR");
      expect_sig(S_WR,      16'h0, "rst_run_wr_count");
      exp_rd = 0; exp_wr = 0;
      tick();
      rst = 1'b0;
      wait_load_ready("reload1", 1'b1);
      load_beat(8'h00, 16'h7777, 1'b0);
      load_beat(8'h01, 16'h8888, 1'b0);
      rst = 1'b1;
      #1;
      expect_sig(S_CPU_RST,    16'h1, "rst_load_cpu_rst");
      expect_sig(S_LOAD_READY, 16'h0, "rst_load_ready");
      tick();
      rst = 1'b0;
      wait_load_ready("reload2", 1'b1);
      check_read(8'h00, 16'h0000, "load_state_dataR");
      load_beat(8'h02, 16'h0093, 1'b1);
      tick();
      check_read(8'h00, 16'h0000, "partial_0_erased");
      check_read(8'h01, 16'h0000, "partial_1_erased");
      check_read(8'h02, 16'h0093, "reload_2");

      cpu_write(8'd20, 16'hBEEF);
      cpu_write(8'd21, 16'h0F0F);
      cpu_write(8'd22, 16'h1357);
      cpu_read(8'd20, 16'hBEEF);
      cpu_read(8'd21, 16'h0F0F);
      cpu_read(8'd22, 16'h1357);
      cpu_read(8'd02, 16'h0093);
      cpu_read(8'd03, 16'h0000);
      expect_sig(S_RD, stat(exp_rd), "rd_count_5");
      expect_sig(S_WR, stat(exp_wr), "wr_count_3");
      tick();

`ifdef NANO_MEM_STATS_EN
      force u_dut.u_rd_count.count_q = 16'hFFFD;
      #1;
      release u_dut.u_rd_count.count_q;
`endif
      for (int i = 0; i < 4; i++) cpu_read(8'd02, 16'h0093);
      expect_sig(S_RD, STATS ? 16'hFFFF : 16'h0000, "rd_count_saturate");
      tick();
      tick();

      total++;
      if (io_q.size() == 0) passed++;
      else $display("FAIL io_strobe_missing: got %0d unmatched io writes expected 0", io_q.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
